// File: rtl/gray_pkg.sv
// Shared definitions for the grayscale frame stage: rounding modes, FSM states
// and the byte lanes of a packed {B, G, R} pixel.
package gray_pkg;

    localparam logic [1:0] RND_UP   = 2'b00;
    localparam logic [1:0] RND_DOWN = 2'b01;
    localparam logic [1:0] RND_EVEN = 2'b10;

    localparam int R_LSB = 0;
    localparam int G_LSB = 8;
    localparam int B_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/gray_frame_ctrl_if.sv
// Pixel streams around the frame controller: RGB in, gray plus line/frame markers out.
// slave is the controller side; master is the side that feeds and drains it.
interface gray_frame_ctrl_if;

    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_sol;
    logic        m_eol;
    logic        m_eof;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_sol, m_eol, m_eof
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_sol, m_eol, m_eof
    );

endinterface

// File: rtl/grayscale.sv
// Combinational RGB to gray core: (5R + 9G + 2B) / 16 with selectable rounding.
// Mode 2'b11 is treated as truncation.
module grayscale
    import gray_pkg::*;
(
    input  logic [23:0] rgb_i,
    input  logic [1:0]  mode_i,
    output logic [7:0]  gray_o
);

    logic [11:0] sum;
    logic [7:0]  whole;
    logic [3:0]  frac;
    logic        round_up;

    assign sum = 12'd5 * {4'd0, rgb_i[R_LSB +: 8]}
               + 12'd9 * {4'd0, rgb_i[G_LSB +: 8]}
               + 12'd2 * {4'd0, rgb_i[B_LSB +: 8]};
    assign whole = sum[11:4];
    assign frac  = sum[3:0];

    always_comb begin
        case (mode_i)
            RND_UP:   round_up = (frac != 4'd0);
            RND_EVEN: round_up = (frac > 4'd8) || ((frac == 4'd8) && whole[0]);
            default:  round_up = 1'b0;
        endcase
    end

    // whole is 255 only when sum is 4080, whose fraction is zero, so no wrap.
    assign gray_o = whole + {7'd0, round_up};

endmodule

// File: rtl/gray_frame_ctrl.sv
// Frame sequencer: latches geometry/mode on start, converts one pixel per beat and
// tags outputs with start-of-line, end-of-line and end-of-frame markers.
//
//   state    | meaning
//   ST_IDLE  | waiting for start, outputs quiet
//   ST_RUN   | accepting pixels, one output register stage
//   ST_DRAIN | last pixel taken, waiting for the eof beat to leave
//   ST_DONE  | one-cycle done pulse
module gray_frame_ctrl
    import gray_pkg::*;
#(
    parameter int DIM_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DIM_W-1:0]   cfg_width,
    input  logic [DIM_W-1:0]   cfg_height,
    input  logic [1:0]         cfg_mode,
    output logic               busy,
    output logic               done,
    gray_frame_ctrl_if.slave   bus
);

    state_e           state_q, state_d;
    logic [DIM_W-1:0] width_q, height_q;
    logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
    logic [1:0]       mode_q;
    logic             m_valid_q, m_sol_q, m_eol_q, m_eof_q;
    logic [7:0]       m_data_q;
    logic [7:0]       gray;
    logic             start_ok, zero_size, s_fire, x_last, y_last;

    assign start_ok  = (state_q == ST_IDLE) && start;
    assign zero_size = (cfg_width == '0) || (cfg_height == '0);
    assign x_last    = (x_q == width_q - DIM_W'(1));
    assign y_last    = (y_q == height_q - DIM_W'(1));
    assign s_fire    = bus.s_valid && bus.s_ready;

    grayscale u_grayscale (
        .rgb_i  (bus.s_data),
        .mode_i (mode_q),
        .gray_o (gray)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = zero_size ? ST_DONE : ST_RUN;
            ST_RUN:   if (s_fire && x_last && y_last) state_d = ST_DRAIN;
            ST_DRAIN: if (m_valid_q && bus.m_ready) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        bus.s_ready = (state_q == ST_RUN) && (!m_valid_q || bus.m_ready);
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (start_ok) begin
            x_d = '0;
            y_d = '0;
        end else if (s_fire) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_q + DIM_W'(1);
            end else begin
                x_d = x_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            width_q   <= '0;
            height_q  <= '0;
            mode_q    <= RND_UP;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sol_q   <= 1'b0;
            m_eol_q   <= 1'b0;
            m_eof_q   <= 1'b0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            if (start_ok) begin
                width_q  <= cfg_width;
                height_q <= cfg_height;
                mode_q   <= cfg_mode;
            end
            // s_ready already guarantees the register is empty or draining here.
            if (s_fire) begin
                m_valid_q <= 1'b1;
                m_data_q  <= gray;
                m_sol_q   <= (x_q == '0);
                m_eol_q   <= x_last;
                m_eof_q   <= x_last && y_last;
            end else if (bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_sol   = m_sol_q;
    assign bus.m_eol   = m_eol_q;
    assign bus.m_eof   = m_eof_q;

endmodule
